prf_multiport: RTL
==================

PRF_MULTIPORT -- requirements
Module: prf_multiport

Interface
REQ-001 SHALL have parameter PHYS_REGS, default 64: number of physical registers (power of two, >=8).
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter EPOCH_W, default 2: epoch tag width.
REQ-004 SHALL have parameters NUM_RD/NUM_WB/NUM_ALLOC, defaults 4/2/2: read, writeback, alloc port counts; PHYS_W = $clog2(PHYS_REGS) is derived.
REQ-005 SHALL have clk  input  1  sole clock, rising edge.
REQ-006 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have rd_addr[NUM_RD]  input  PHYS_W each; rd_data[NUM_RD]  output  DW; rd_ready[NUM_RD]  output  1.
REQ-008 SHALL have alloc_valid[NUM_ALLOC]  input  1; alloc_pd  input  PHYS_W; alloc_epoch  input  EPOCH_W.
REQ-009 SHALL have wb_valid[NUM_WB]  input  1; wb_pd  input  PHYS_W; wb_data  input  DW; wb_epoch  input  EPOCH_W; wb_ack[NUM_WB]  output  1.
REQ-010 SHALL have wakeup_valid[NUM_WB]  output  1; wakeup_pd[NUM_WB]  output  PHYS_W.
REQ-011 SHALL have init_busy  output  1; ready_vec  output  PHYS_REGS; stale_drop_cnt  output  16.

Function
REQ-012 Reads SHALL be combinational: rd_data/rd_ready = stored data/ready bit of rd_addr.
REQ-013 FSM SHALL have states INIT and RUN; reset enters INIT with sweep pointer 0.
REQ-014 In INIT: one data entry per cycle written to 0, pointer +1; after entry PHYS_REGS-1 is written, next state RUN; init_busy=1 exactly while in INIT (PHYS_REGS cycles).
REQ-015 In INIT: alloc and wb inputs SHALL be ignored, wb_ack=0, no wakeups.
REQ-016 wb_ack[j] SHALL be combinational: wb_valid[j] && RUN && epoch[wb_pd[j]] == wb_epoch[j] (pre-update epoch).
REQ-017 On wb_ack[j]: data[wb_pd[j]] <= wb_data[j]; ready <= 1 unless an alloc_valid in the same cycle targets the same pd.
REQ-018 On alloc_valid[i] in RUN: ready[alloc_pd[i]] <= 0, epoch[alloc_pd[i]] <= alloc_epoch[i]; alloc beats wb on ready/epoch, wb data still written.
REQ-019 Same pd on multiple wb ports or multiple alloc ports in one cycle: highest port index SHALL win.
REQ-020 wakeup_valid[j]/wakeup_pd[j] SHALL be registered, asserted one cycle after wb_ack[j], suppressed if the ready bit was overridden by a same-cycle alloc.
REQ-021 wb_valid[j] && RUN && !wb_ack[j] counts as stale drop; stale_drop_cnt SHALL add the number of such ports per cycle, saturating at 16'hFFFF.
REQ-022 ready_vec[k] SHALL equal ready[k] continuously.

Reset
REQ-023 On rst_n low, immediately: all ready=1, all epoch=0, state INIT, pointer 0, wakeup_valid=0, wakeup_pd=0, stale_drop_cnt=0, init_busy=1.
REQ-024 Data array SHALL NOT be reset asynchronously; it is cleared only by the INIT sweep; rd_data is undefined until init_busy falls.
REQ-025 Reset asserted mid-sweep or mid-RUN SHALL restart INIT from pointer 0.

Configuration
REQ-026 Macro PRF_BYPASS_EN defined: if rd_addr[r] equals wb_pd[j] with wb_ack[j] this cycle, rd_data[r]=wb_data[j], rd_ready[r]=1 (highest j wins; same-cycle alloc to that pd forces rd_ready=0).
REQ-027 PRF_BYPASS_EN undefined: reads return stored state only; accepted writes visible the next cycle.

Verification
REQ-028 Reset, hold 70 cycles -> init_busy high exactly 64 cycles after release; all rd_data=0, ready_vec all ones.
REQ-029 alloc pd=5 epoch=1; next cycle wb pd=5 epoch=1 data 32'hDEADBEEF -> wb_ack=1, next cycle rd_ready=1, rd_data=DEADBEEF, wakeup_valid=1 wakeup_pd=5.
REQ-030 alloc pd=7 epoch=2; wb pd=7 epoch=1 -> wb_ack=0, data unchanged, rd_ready=0, stale_drop_cnt +1.
REQ-031 Same cycle: alloc pd=9 epoch=0 and wb0 pd=9 epoch=0 data 0x55 -> next cycle ready=0, data=0x55, no wakeup.
REQ-032 wb0 and wb1 both pd=3 with data 0x11/0x22 -> stored 0x22; with PRF_BYPASS_EN, same-cycle read of pd 3 returns 0x22 ready=1.
REQ-033 Drive 70000 stale writebacks -> stale_drop_cnt holds 16'hFFFF; rst_n low mid-sweep at pointer 20 -> sweep restarts at 0.

Source files
------------

// File: rtl/prf_multiport.sv
//------------------------------------------------------------------------------
// Module   : prf_multiport
// Purpose  : Multi-ported physical register file with ready/epoch tracking,
//            writeback wakeups and an INIT sweep that clears the data array.
// Options  : PRF_BYPASS_EN - forward same-cycle accepted writebacks to reads.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prf_multiport #(
  parameter int PHYS_REGS = 64,
  parameter int DW        = 32,
  parameter int EPOCH_W   = 2,
  parameter int NUM_RD    = 4,
  parameter int NUM_WB    = 2,
  parameter int NUM_ALLOC = 2,
  parameter int PHYS_W    = $clog2(PHYS_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PHYS_W-1:0]    rd_addr     [NUM_RD],
  output logic [DW-1:0]        rd_data     [NUM_RD],
  output logic [NUM_RD-1:0]    rd_ready,
  input  logic [NUM_ALLOC-1:0] alloc_valid,
  input  logic [PHYS_W-1:0]    alloc_pd    [NUM_ALLOC],
  input  logic [EPOCH_W-1:0]   alloc_epoch [NUM_ALLOC],
  input  logic [NUM_WB-1:0]    wb_valid,
  input  logic [PHYS_W-1:0]    wb_pd       [NUM_WB],
  input  logic [DW-1:0]        wb_data     [NUM_WB],
  input  logic [EPOCH_W-1:0]   wb_epoch    [NUM_WB],
  output logic [NUM_WB-1:0]    wb_ack,
  output logic [NUM_WB-1:0]    wakeup_valid,
  output logic [PHYS_W-1:0]    wakeup_pd   [NUM_WB],
  output logic                 init_busy,
  output logic [PHYS_REGS-1:0] ready_vec,
  output logic [15:0]          stale_drop_cnt
);

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [PHYS_W-1:0]    ptr_q, ptr_d;
  logic [DW-1:0]        data_q [PHYS_REGS];
  logic [DW-1:0]        data_d [PHYS_REGS];
  logic [PHYS_REGS-1:0] ready_q, ready_d;
  logic [EPOCH_W-1:0]   epoch_q [PHYS_REGS];
  logic [EPOCH_W-1:0]   epoch_d [PHYS_REGS];
  logic [NUM_WB-1:0]    wakeup_valid_q, wakeup_valid_d;
  logic [PHYS_W-1:0]    wakeup_pd_q [NUM_WB];
  logic [PHYS_W-1:0]    wakeup_pd_d [NUM_WB];
  logic [15:0]          stale_q, stale_d;
  logic [16:0]          stale_sum;
  logic [7:0]           drop_cnt;
  logic [NUM_WB-1:0]    wb_alloc_hit;
  logic                 run;

  assign run = (state_q == RUN);

  // Epoch match uses the pre-update epoch, so a same-cycle alloc cannot retag a writeback.
  always_comb begin : ack_logic
    wb_ack       = '0;
    wb_alloc_hit = '0;
    drop_cnt     = '0;
    for (int j = 0; j < NUM_WB; j++) begin
      wb_ack[j] = wb_valid[j] && run && (epoch_q[wb_pd[j]] == wb_epoch[j]);
      for (int i = 0; i < NUM_ALLOC; i++) begin
        if (alloc_valid[i] && (alloc_pd[i] == wb_pd[j])) wb_alloc_hit[j] = 1'b1;
      end
      if (wb_valid[j] && run && !wb_ack[j]) drop_cnt = drop_cnt + 8'd1;
    end
  end

  always_comb begin : next_state
    state_d        = state_q;
    ptr_d          = ptr_q;
    data_d         = data_q;
    ready_d        = ready_q;
    epoch_d        = epoch_q;
    wakeup_valid_d = '0;
    wakeup_pd_d    = wakeup_pd_q;
    if (state_q == INIT) begin
      data_d[ptr_q] = '0;
      ptr_d         = ptr_q + 1'b1;
      if (ptr_q == PHYS_W'(PHYS_REGS - 1)) state_d = RUN;
    end else begin
      // Ascending port order lets the highest index win on collisions.
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_ack[j]) begin
          data_d[wb_pd[j]] = wb_data[j];
          wakeup_pd_d[j]   = wb_pd[j];
          if (!wb_alloc_hit[j]) begin
            ready_d[wb_pd[j]] = 1'b1;
            wakeup_valid_d[j] = 1'b1;
          end
        end
      end
      for (int i = 0; i < NUM_ALLOC; i++) begin
        if (alloc_valid[i]) begin
          ready_d[alloc_pd[i]] = 1'b0;
          epoch_d[alloc_pd[i]] = alloc_epoch[i];
        end
      end
    end
    stale_sum = {1'b0, stale_q} + 17'(drop_cnt);
    stale_d   = stale_sum[16] ? 16'hFFFF : stale_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= INIT;
      ptr_q          <= '0;
      ready_q        <= '1;
      wakeup_valid_q <= '0;
      stale_q        <= '0;
      for (int k = 0; k < PHYS_REGS; k++) epoch_q[k] <= '0;
      for (int j = 0; j < NUM_WB; j++) wakeup_pd_q[j] <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      ready_q        <= ready_d;
      epoch_q        <= epoch_d;
      wakeup_valid_q <= wakeup_valid_d;
      wakeup_pd_q    <= wakeup_pd_d;
      stale_q        <= stale_d;
    end
  end

  // Data array has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_comb begin : read_ports
    rd_ready = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data[r]  = data_q[rd_addr[r]];
      rd_ready[r] = ready_q[rd_addr[r]];
`ifdef PRF_BYPASS_EN
      for (int j = 0; j < NUM_WB; j++) begin
        if (wb_ack[j] && (wb_pd[j] == rd_addr[r])) begin
          rd_data[r]  = wb_data[j];
          rd_ready[r] = !wb_alloc_hit[j];
        end
      end
`endif
    end
  end

  assign wakeup_valid   = wakeup_valid_q;
  assign wakeup_pd      = wakeup_pd_q;
  assign init_busy      = (state_q == INIT);
  assign ready_vec      = ready_q;
  assign stale_drop_cnt = stale_q;

endmodule

`default_nettype wire
